// File: rtl/divider_pkg.sv
// Shared types and helpers for the runtime-programmable divide-by-N tick generator.
package divider_pkg;

  localparam int unsigned DIV_MIN = 1;
  localparam int unsigned HC_W    = 33;

  typedef enum logic {
    RUN  = 1'b0,
    HOLD = 1'b1
  } mode_t;

  // (n+1)>>1 evaluated one bit wider than n so n = all-ones cannot overflow.
  function automatic logic [HC_W-1:0] half_ceil(input logic [HC_W-2:0] n);
    return (HC_W'(n) + HC_W'(1)) >> 1;
  endfunction

endpackage

// File: rtl/mod_n_counter.sv
// Modulo-N counter with hold, synchronous clear and a period-boundary flag.
module mod_n_counter #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic             clr,
  input  logic [WIDTH-1:0] div,
  output logic [WIDTH-1:0] count,
  output logic             wrap
);

  logic [WIDTH-1:0] count_nxt;
  logic             at_end;
  logic             out_range;

  // div is never 0, so div-1 cannot underflow.
  assign at_end    = (count >= div - WIDTH'(1));
  assign out_range = (count >= div);
  assign wrap      = !clr && (out_range || (en && at_end));

  always_comb begin
    count_nxt = count;
    if (clr || out_range) begin
      count_nxt = '0;
    end else if (en) begin
      count_nxt = at_end ? '0 : count + WIDTH'(1);
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      count <= '0;
    end else begin
      count <= count_nxt;
    end
  end

endmodule

// File: rtl/divide_by_n_fsm.sv
// Divide-by-N tick/square-wave source; divisor reloads only at a period boundary.
module divide_by_n_fsm
  import divider_pkg::*;
#(
  parameter int unsigned WIDTH       = 8,
  parameter int unsigned DEFAULT_DIV = 3
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic             clr,
  input  logic             div_load,
  input  logic [WIDTH-1:0] div_in,
  output logic             y,
  output logic             y_sq,
  output logic [WIDTH-1:0] count,
  output logic [WIDTH-1:0] div,
  output logic             pend,
  output logic             err
);

  logic [WIDTH-1:0] pend_div;
  logic [WIDTH-1:0] div_nxt;
  logic [WIDTH-1:0] pend_div_nxt;
  logic             pend_nxt;
  logic             err_nxt;
  logic             wrap;
  logic             boundary;
  logic             load_ok;
  logic [WIDTH:0]   thr;
  mode_t            mode_c;

  mod_n_counter #(
    .WIDTH (WIDTH)
  ) u_cnt (
    .clk   (clk),
    .reset (reset),
    .en    (en),
    .clr   (clr),
    .div   (div),
    .count (count),
    .wrap  (wrap)
  );

  assign boundary = wrap || clr;
  assign load_ok  = div_load && (div_in >= WIDTH'(DIV_MIN));
  assign mode_c   = (en || clr) ? RUN : HOLD;

  // A load coinciding with a boundary bypasses the pending register.
  always_comb begin
    div_nxt      = div;
    pend_div_nxt = pend_div;
    pend_nxt     = pend;
    err_nxt      = err;
    if (div_load && !load_ok) begin
      err_nxt = 1'b1;
    end
    if (boundary) begin
      pend_nxt = 1'b0;
      if (load_ok) begin
        div_nxt = div_in;
      end else if (pend) begin
        div_nxt = pend_div;
      end
    end else if (load_ok) begin
      pend_div_nxt = div_in;
      pend_nxt     = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      div      <= WIDTH'(DEFAULT_DIV);
      pend_div <= '0;
      pend     <= 1'b0;
      err      <= 1'b0;
    end else begin
      div      <= div_nxt;
      pend_div <= pend_div_nxt;
      pend     <= pend_nxt;
      err      <= err_nxt;
    end
  end

  assign thr  = (WIDTH+1)'(half_ceil((HC_W-1)'(div)));
  assign y    = (count == '0);
  assign y_sq = ((WIDTH+1)'(count) < thr);

  a_hold_stable: assert property (@(posedge clk) disable iff (!reset)
                                  (mode_c == HOLD) |=> $stable(count));

endmodule

// File: tb/tb_divide_by_n_fsm.sv
// Scoreboard bench for divide_by_n_fsm: directed steps push expected post-edge state.
module tb_divide_by_n_fsm;

  typedef struct {
    int c;
    int d;
    int p;
    int e;
    int y;
    int s;
    int id;
  } exp_t;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       en = 1'b0;
  logic       clr = 1'b0;
  logic       div_load = 1'b0;
  logic [7:0] div_in = 8'd0;
  logic       y;
  logic       y_sq;
  logic [7:0] count;
  logic [7:0] div;
  logic       pend;
  logic       err;

  exp_t sb[$];
  int   vectors = 0;
  int   miscompares = 0;
  int   step_no = 0;

  divide_by_n_fsm #(.WIDTH(8), .DEFAULT_DIV(3)) dut (
    .clk      (clk),
    .reset    (reset),
    .en       (en),
    .clr      (clr),
    .div_load (div_load),
    .div_in   (div_in),
    .y        (y),
    .y_sq     (y_sq),
    .count    (count),
    .div      (div),
    .pend     (pend),
    .err      (err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int expv);
    vectors++;
    if (act != expv) begin
      miscompares++;
      $display("FAIL %s: got %0d expected %0d", name, act, expv);
    end
  endtask

  task automatic chk_all(input string tag, input int c, input int d, input int p,
                         input int e, input int yy, input int s);
    chk({tag, " count"}, int'(count), c);
    chk({tag, " div"},   int'(div),   d);
    chk({tag, " pend"},  int'(pend),  p);
    chk({tag, " err"},   int'(err),   e);
    chk({tag, " y"},     int'(y),     yy);
    chk({tag, " y_sq"},  int'(y_sq),  s);
  endtask

  // Drive one edge's inputs and queue the state expected right after that edge.
  task automatic step(input logic i_en, input logic i_clr, input logic i_ld,
                      input logic [7:0] i_din, input int c, input int d,
                      input int p, input int e, input int yy, input int s);
    exp_t x;
    @(negedge clk);
    en = i_en; clr = i_clr; div_load = i_ld; div_in = i_din;
    step_no++;
    x.c = c; x.d = d; x.p = p; x.e = e; x.y = yy; x.s = s; x.id = step_no;
    sb.push_back(x);
  endtask

  initial begin : monitor
    exp_t x;
    forever begin
      @(posedge clk);
      #1;
      if (sb.size() > 0) begin
        x = sb.pop_front();
        chk_all($sformatf("step%0d", x.id), x.c, x.d, x.p, x.e, x.y, x.s);
      end
    end
  end

  initial begin : stim
    repeat (2) @(posedge clk);
    #2;
    chk_all("reset", 0, 3, 0, 0, 1, 1);
    @(negedge clk);
    reset = 1'b1;

    // N=3 free run
    step(1, 0, 0, 0,   1, 3, 0, 0, 0, 1);
    step(1, 0, 0, 0,   2, 3, 0, 0, 0, 0);
    step(1, 0, 0, 0,   0, 3, 0, 0, 1, 1);
    step(1, 0, 0, 0,   1, 3, 0, 0, 0, 1);
    step(1, 0, 0, 0,   2, 3, 0, 0, 0, 0);
    step(1, 0, 0, 0,   0, 3, 0, 0, 1, 1);
    step(1, 0, 0, 0,   1, 3, 0, 0, 0, 1);
    // load 5 mid-period, applied at the wrap
    step(1, 0, 1, 5,   2, 3, 1, 0, 0, 0);
    step(1, 0, 0, 0,   0, 5, 0, 0, 1, 1);
    step(1, 0, 0, 0,   1, 5, 0, 0, 0, 1);
    step(1, 0, 0, 0,   2, 5, 0, 0, 0, 1);
    step(1, 0, 0, 0,   3, 5, 0, 0, 0, 0);
    step(1, 0, 0, 0,   4, 5, 0, 0, 0, 0);
    step(1, 0, 0, 0,   0, 5, 0, 0, 1, 1);
    step(1, 0, 0, 0,   1, 5, 0, 0, 0, 1);
    step(1, 0, 0, 0,   2, 5, 0, 0, 0, 1);
    step(1, 0, 0, 0,   3, 5, 0, 0, 0, 0);
    step(1, 0, 0, 0,   4, 5, 0, 0, 0, 0);
    // load 4 on the exact wrap edge
    step(1, 0, 1, 4,   0, 4, 0, 0, 1, 1);
    step(1, 0, 0, 0,   1, 4, 0, 0, 0, 1);
    step(1, 0, 0, 0,   2, 4, 0, 0, 0, 0);
    step(1, 0, 0, 0,   3, 4, 0, 0, 0, 0);
    step(1, 0, 0, 0,   0, 4, 0, 0, 1, 1);
    // zero divisor load sets sticky err
    step(1, 0, 1, 0,   1, 4, 0, 1, 0, 1);
    step(1, 0, 0, 0,   2, 4, 0, 1, 0, 0);
    // loads while disabled: overwrite, zero load leaves pending intact
    step(0, 0, 1, 7,   2, 4, 1, 1, 0, 0);
    step(0, 0, 1, 6,   2, 4, 1, 1, 0, 0);
    step(0, 0, 1, 0,   2, 4, 1, 1, 0, 0);
    step(1, 0, 0, 0,   3, 4, 1, 1, 0, 0);
    step(1, 0, 0, 0,   0, 6, 0, 1, 1, 1);
    step(1, 0, 0, 0,   1, 6, 0, 1, 0, 1);
    step(1, 0, 0, 0,   2, 6, 0, 1, 0, 1);
    // hold at count 2 of N=6, then clear while disabled
    step(0, 0, 0, 0,   2, 6, 0, 1, 0, 1);
    step(0, 0, 0, 0,   2, 6, 0, 1, 0, 1);
    step(0, 0, 0, 0,   2, 6, 0, 1, 0, 1);
    step(0, 0, 0, 0,   2, 6, 0, 1, 0, 1);
    step(0, 1, 0, 0,   0, 6, 0, 1, 1, 1);
    // pending N=1 applied by clr, then constant high outputs
    step(0, 0, 1, 1,   0, 6, 1, 1, 1, 1);
    step(0, 1, 0, 0,   0, 1, 0, 1, 1, 1);
    step(1, 0, 0, 0,   0, 1, 0, 1, 1, 1);
    step(1, 0, 0, 0,   0, 1, 0, 1, 1, 1);
    step(1, 0, 0, 0,   0, 1, 0, 1, 1, 1);
    // load together with clr applies directly
    step(1, 1, 1, 5,   0, 5, 0, 1, 1, 1);
    step(1, 0, 1, 2,   1, 5, 1, 1, 0, 1);
    step(1, 0, 0, 0,   2, 5, 1, 1, 0, 1);
    step(1, 0, 0, 0,   3, 5, 1, 1, 0, 0);

    // asynchronous reset mid-period discards pending and clears err
    @(negedge clk);
    en = 1'b0; clr = 1'b0; div_load = 1'b0; div_in = 8'd0;
    #2 reset = 1'b0;
    #1 chk_all("async_reset", 0, 3, 0, 0, 1, 1);
    @(negedge clk);
    reset = 1'b1;
    step(1, 0, 0, 0,   1, 3, 0, 0, 0, 1);
    step(1, 0, 0, 0,   2, 3, 0, 0, 0, 0);

    repeat (3) @(posedge clk);
    #3;
    if (sb.size() != 0) begin
      vectors++;
      miscompares++;
      $display("FAIL drain: got %0d pending entries expected 0", sb.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin : watchdog
    #20000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

endmodule

// File: doc/divide_by_n_fsm.md
Name: divide_by_n_fsm

Overview:
- Parametrised successor of the fixed divide-by-3 state machine: a modulo-N counter whose divisor is changed at runtime.
- Produces a one-in-N pulse (y), asserted in the count-0 "S0" state, and an approximately 50% duty square wave (y_sq).
- Adds enable, synchronous clear and glitch-free divisor reload: a new divisor takes effect only at a period boundary.
- Used as a generic tick/clock-enable source for downstream lesson blocks.

Parameters:
WIDTH  8  bit width of counter and divisor; maximum divisor is 2^WIDTH-1
DEFAULT_DIV  3  divisor loaded at reset; must be in the range 1..2^WIDTH-1

Ports:
clk  input  1  single clock, all state updates on rising edge
reset  input  1  asynchronous, active-low reset
en  input  1  count enable; when low, all count state holds
clr  input  1  synchronous clear; forces the counter to period start
div_load  input  1  one-cycle strobe that captures div_in as the pending divisor
div_in  input  WIDTH  requested divisor N
y  output  1  high while count==0 (one cycle in N when enabled)
y_sq  output  1  high while count < ceil(N/2)
count  output  WIDTH  current count, range 0..N-1
div  output  WIDTH  divisor currently in effect
pend  output  1  a loaded divisor is waiting for the next boundary
err  output  1  sticky flag: a load with div_in==0 was attempted

Behaviour:
- Interface: one clock; reset is asynchronous and active-low. The clock port is clk and the reset port is reset.
- Reset values while reset is low, applied immediately:
  - count=0, div=DEFAULT_DIV, pending register=0, pend=0, err=0.
  - Consequently y=1 and y_sq=1.
- Outputs y and y_sq are combinational decodes of the registered count and div; there is no extra latency.
- Counting, on each rising edge with en=1 and clr=0:
  - If count==div-1, count wraps to 0 (the wrap boundary).
  - Otherwise count increments by 1.
- en=0 and clr=0: count holds, so y and y_sq hold their values.
- clr=1: count goes to 0 on the next edge regardless of en. clr has priority over en.
- Divisor reload:
  - div_load=1 with div_in!=0: the pending register captures div_in and pend=1. A later load before the boundary overwrites the pending value.
  - At the next boundary (a wrap, or an edge with clr=1): div takes the pending value, pend clears and count goes to 0, all on that same edge.
  - Load and boundary on the same edge: the new value (div_in) is applied directly at that edge and pend stays 0.
  - div_load=1 with div_in==0: ignored. err is set and stays set until reset; pend and the pending value are unchanged.
  - A load while en=0 stays pending until a wrap or clr occurs.
- Divisor N=1: count stays at 0, so y=1 and y_sq=1 continuously.
- Period of y with en=1 is exactly N cycles. For N>1, y is high 1 cycle in N.
- y_sq:
  - The threshold (div+1)>>1 is computed at WIDTH+1 bits to avoid overflow when div=2^WIDTH-1.
  - Odd N: y_sq is high for (N+1)/2 cycles.
  - Even N: y_sq is high for N/2 cycles.
- Reset asserted mid-period: outputs return to reset values immediately and any pending divisor is discarded.
- Counter state has no illegal encodings. A safety rule still applies: if count>=div (unreachable), the next edge forces count to 0.

Decomposition:
- Package divider_pkg holds:
  - typedef enum {RUN, HOLD} mode_t, used for debug/assertions.
  - Function half_ceil(N), returning (N+1)>>1 at WIDTH+1 bits.
  - Constant DIV_MIN=1.
- One natural sub-module: mod_n_counter, a modulo-N counter with en, clr and wrap output.
- Parent block divide_by_n_fsm owns the divisor and pending registers, err, and the output decode.

Test Plan:
- Reset, then en=1 with DEFAULT_DIV=3 for 9 cycles -> count sequence 0,1,2,0,1,2,0,1,2; y=1 at counts 0 only; y_sq=1 at counts 0 and 1.
- At count=1 of N=3, div_load with div_in=5 -> pend=1; on the wrap edge div=5 and pend=0; next period y has a 5-cycle period and y_sq is high 3 cycles.
- div_load with div_in=4 on the exact wrap edge -> div=4 on that edge, pend stays 0; next period is 4 cycles, y_sq high 2.
- div_load with div_in=0 -> err=1, div unchanged, pend unchanged; err persists until reset is driven low.
- en=0 at count=2 of N=6 for 4 cycles -> count holds at 2; then clr=1 with en=0 -> count=0 and y=1 next edge.
- div=1 loaded, then reset pulsed low mid-run -> before reset, y=1 and y_sq=1 constantly; during reset, count=0, div=3, pend=0.
